decode_stage: RTL
=================

# decode_stage

Registered RV32/RV64 instruction-decode pipeline stage. It is the parametrised successor to the combinational `InstrDecoder`. It takes a fetched instruction and PC from fetch over a valid/ready handshake, then produces:
- the immediate-type class (`ImmSrc`) and the fully sign-extended immediate value;
- register indices and core control flags;
- an illegal-instruction flag.

An optional skid buffer (`SKID=1`) breaks the combinational `ready` path. It sits between fetch and the register-read/execute stage.

## Interface
- `XLEN`, 32, datapath width for PC and immediate; legal values 32 or 64.
- `SKID`, 1, 1 = two-entry skid buffer (registered `o_ready`); 0 = single output register (`o_ready` combinational from `i_ready`).
- `i_clk  input  1  clock, all state on rising edge.`
- `i_rst_n  input  1  asynchronous active-low reset.`
- `i_flush  input  1  synchronous flush; drops all held and incoming instructions.`
- `i_valid  input  1  upstream instruction valid.`
- `o_ready  output  1  stage can accept an instruction this cycle.`
- `i_instr  input  32  instruction word.`
- `i_pc  input  XLEN  PC of i_instr.`
- `o_valid  output  1  decoded bundle valid.`
- `i_ready  input  1  downstream accepts bundle.`
- `o_pc  output  XLEN  PC passed through.`
- `o_imm_src  output  3  NO=0, RT=1, IT=2, ST=3, BT=4, UT=5, JT=6.`
- `o_imm  output  XLEN  sign-extended immediate (0 for NO/RT).`
- `o_rd, o_rs1, o_rs2  output  5 each  register indices from instr[11:7], [19:15], [24:20].`
- `o_reg_we  output  1  writes rd (RT, IT, UT, JT; forced 0 when rd==0).`
- `o_mem_rd / o_mem_wr  output  1 each  LOAD / STORE opcode.`
- `o_branch / o_jump  output  1 each  BRANCH / JAL or JALR.`
- `o_illegal  output  1  unrecognised opcode or instr[1:0] != 2'b11.`

## Operation
**Opcode to `ImmSrc` mapping**
- `0110011` → RT.
- `0010011`, `0000011`, `1100111`, `1110011` → IT.
- `0100011` → ST.
- `1100011` → BT.
- `1101111` → JT.
- `0?10111` → UT.
- Anything else → NO with `o_illegal=1`.
- For `XLEN=64`, `0011011` (OP-IMM-32) → IT and `0111011` (OP-32) → RT.

**Immediate formats** (sign bit is instr[31], extended to XLEN)
- IT = instr[31:20].
- ST = {instr[31:25], instr[11:7]}.
- BT = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- UT = {instr[31:12], 12'b0}.
- JT = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.

**Handshake**
- An instruction transfers upstream when `i_valid && o_ready`.
- A bundle transfers downstream when `o_valid && i_ready`.
- While `o_valid && !i_ready`, all outputs hold stable.
- Order is strictly preserved.
- Illegal instructions flow through like any other instruction, with `o_illegal=1`.

**SKID=0**
- Single entry.
- `o_ready = !o_valid || i_ready`.

**SKID=1**
- States are EMPTY, ONE (output register full), and TWO (output and skid full).
- `o_ready` is registered and equals 1 exactly when the state is not TWO.
- EMPTY → ONE on accept.
- ONE → TWO on accept without drain.
- ONE → EMPTY on drain without accept.
- ONE with accept and drain stays in ONE, and the new bundle loads the output register.
- TWO → ONE on drain: the skid entry moves into the output register the same cycle.

**Flush**
- On `i_flush=1`, the next state is EMPTY.
- `o_valid` is 0 the following cycle.
- An instruction presented that cycle is discarded even if `i_valid && o_ready`.
- Flush has priority over every other event.

## Timing
- Latency is 1 cycle from the accept edge to `o_valid=1` with the decoded bundle.
- Sustained throughput is 1 instruction per cycle with `i_ready=1`, for both SKID settings.
- Reset (asynchronous, takes effect immediately whenever asserted):
  - `o_valid=0`;
  - every data output is 0 (`o_imm_src=NO`, `o_illegal=0`);
  - `o_ready=1` for SKID=1, or follows the combinational rule for SKID=0;
  - state is EMPTY.
- Reset asserted mid-stream loses all held entries, with no partial outputs.
- Decode logic is purely combinational on `i_instr`. It is registered only at the output and skid entries; no decode occurs on the output side.

## Structure
- Shared package `decode_pkg`:
  - `ImmSrc` localparams NO..JT (3 bits, values above);
  - opcode constants (OP, OP_IMM, LOAD, JALR, SYSTEM, STORE, BRANCH, JAL, LUI, AUIPC, OP_IMM_32, OP_32).
- Sub-module `imm_gen`: combinational, parameter XLEN, inputs instr[31:7] and `ImmSrc`, output sign-extended `o_imm`.
- The top level contains the opcode classifier, a bundle struct (PC, imm, src, indices, flags), and the output/skid registers plus control FSM.

## Test plan
- `0xFFF00093` (addi x1,x0,-1), XLEN=32 → `o_imm_src=2`, `o_imm=0xFFFFFFFF`, `o_rd=1`, `o_reg_we=1`, `o_valid` one cycle after accept.
- `0xFE000EE3` (beq x0,x0,-4) → `o_imm_src=4`, `o_imm=0xFFFFFFFC`, `o_branch=1`, `o_reg_we=0`.
- XLEN=64, `0x123452B7` (lui x5,0x12345) → `o_imm_src=5`, `o_imm=0x0000000012345000`, `o_rd=5`.
- `0x00000000` → `o_illegal=1`, `o_imm_src=0`, `o_valid=1`, `o_imm=0`.
- SKID=1, `i_ready=0`, three back-to-back valid instructions:
  - first two accepted;
  - `o_ready=0` on the third, which is held upstream;
  - release `i_ready` → all three emerge in order on consecutive cycles.
- In state TWO, pulse `i_flush` with `i_valid=1` → next cycle `o_valid=0`, `o_ready=1`, and no instruction from before or during the flush ever appears.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode constants: immediate-class encodings, RV opcodes and the
// stage-control FSM state type.
package decode_pkg;

  localparam logic [2:0] NO = 3'd0;
  localparam logic [2:0] RT = 3'd1;
  localparam logic [2:0] IT = 3'd2;
  localparam logic [2:0] ST = 3'd3;
  localparam logic [2:0] BT = 3'd4;
  localparam logic [2:0] UT = 3'd5;
  localparam logic [2:0] JT = 3'd6;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: assembles the 32-bit immediate for the
// given class, then sign-extends it from instr[31] to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  logic [2:0]      i_imm_src,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (i_imm_src)
      IT: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      ST: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      BT: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
      UT: w_imm32 = {i_instr[31:12], 12'b0};
      JT: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_ext
      assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_noext
      assign o_imm = w_imm32;
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// Registered RV32/RV64 decode stage: combinational classifier + imm_gen feeding
// an output register and optional skid entry under a three-state control FSM.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [2:0]      o_imm_src,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic            o_reg_we,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      src;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            reg_we;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  logic [6:0]      w_opc;
  logic [2:0]      w_src;
  logic            w_ill;
  logic [XLEN-1:0] w_imm;
  bundle_t         w_dec;

  assign w_opc = i_instr[6:0];

  always_comb begin
    w_src = NO;
    w_ill = 1'b0;
    case (w_opc)
      OP:                          w_src = RT;
      OP_IMM, LOAD, JALR, SYSTEM:  w_src = IT;
      STORE:                       w_src = ST;
      BRANCH:                      w_src = BT;
      JAL:                         w_src = JT;
      LUI, AUIPC:                  w_src = UT;
      OP_IMM_32: if (XLEN == 64) w_src = IT; else w_ill = 1'b1;
      OP_32:     if (XLEN == 64) w_src = RT; else w_ill = 1'b1;
      default:                     w_ill = 1'b1;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr   (i_instr[31:7]),
    .i_imm_src (w_src),
    .o_imm     (w_imm)
  );

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = i_pc;
    w_dec.imm     = w_imm;
    w_dec.src     = w_src;
    w_dec.rd      = i_instr[11:7];
    w_dec.rs1     = i_instr[19:15];
    w_dec.rs2     = i_instr[24:20];
    // x0 is hardwired, so a write to it is never requested downstream
    w_dec.reg_we  = (w_src == RT || w_src == IT || w_src == UT || w_src == JT) &&
                    (i_instr[11:7] != 5'd0);
    w_dec.mem_rd  = (w_opc == LOAD);
    w_dec.mem_wr  = (w_opc == STORE);
    w_dec.branch  = (w_opc == BRANCH);
    w_dec.jump    = (w_opc == JAL) || (w_opc == JALR);
    w_dec.illegal = w_ill;
  end

  state_t  r_state, w_state_nxt;
  bundle_t r_out, r_skid;
  logic    w_acc, w_drn, w_ld_out, w_ld_skid, w_mv_skid;

  // Without the skid entry the stage only accepts when the slot drains, so
  // S_TWO is unreachable and the same FSM serves both configurations.
  assign o_ready = SKID ? (r_state != S_TWO) : ((r_state == S_EMPTY) || i_ready);
  assign o_valid = (r_state != S_EMPTY);
  assign w_acc   = i_valid && o_ready;
  assign w_drn   = o_valid && i_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_out    = 1'b0;
    w_ld_skid   = 1'b0;
    w_mv_skid   = 1'b0;
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_acc) begin
          w_state_nxt = S_ONE;
          w_ld_out    = 1'b1;
        end
        S_ONE: begin
          if (w_acc && w_drn) begin
            w_ld_out = 1'b1;
          end else if (w_acc) begin
            w_state_nxt = S_TWO;
            w_ld_skid   = 1'b1;
          end else if (w_drn) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: if (w_drn) begin
          w_state_nxt = S_ONE;
          w_mv_skid   = 1'b1;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_out)       r_out <= w_dec;
      else if (w_mv_skid) r_out <= r_skid;
      if (w_ld_skid)      r_skid <= w_dec;
    end
  end

  assign o_pc      = r_out.pc;
  assign o_imm     = r_out.imm;
  assign o_imm_src = r_out.src;
  assign o_rd      = r_out.rd;
  assign o_rs1     = r_out.rs1;
  assign o_rs2     = r_out.rs2;
  assign o_reg_we  = r_out.reg_we;
  assign o_mem_rd  = r_out.mem_rd;
  assign o_mem_wr  = r_out.mem_wr;
  assign o_branch  = r_out.branch;
  assign o_jump    = r_out.jump;
  assign o_illegal = r_out.illegal;

endmodule
